char_draw_scheduler: RTL and testbench

CHAR_DRAW_SCHEDULER -- requirements
Module: char_draw_scheduler

---
 rtl/char_draw_scheduler_pkg.sv | 16 +
 rtl/char_draw_scheduler_rr_arbiter.sv | 36 +++
 rtl/char_draw_scheduler.sv | 153 +++++++++++++++
 tb/tb_char_draw_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_draw_scheduler_pkg.sv
// Shared rendering package: renderer operand widths and
// the draw scheduler FSM state type.
package char_draw_scheduler_pkg;

    localparam int CHAR_W = 7;
    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int SIZE_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        RELEASE
    } sched_state_t;

endpackage

// File: rtl/char_draw_scheduler_rr_arbiter.sv
// Round-robin priority picker: first valid requester at or
// after ptr, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic [IDX_W:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(NUM_REQ)) begin
                idx = idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!any && valid[idx[IDX_W-1:0]]) begin
                any       = 1'b1;
                grant_idx = idx[IDX_W-1:0];
            end
        end
        if (any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/char_draw_scheduler.sv
// Shares one character renderer among NUM_REQ requesters,
// with round-robin grant, operand capture and a draw watchdog.
module char_draw_scheduler
    import char_draw_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*CHAR_W-1:0]  req_char,
    input  logic [NUM_REQ*X_W-1:0]     req_x,
    input  logic [NUM_REQ*Y_W-1:0]     req_y,
    input  logic [NUM_REQ*SIZE_W-1:0]  req_size,
    output logic [NUM_REQ-1:0]         done,
    output logic                       done_err,
    output logic [CHAR_W-1:0]          r_char,
    output logic [X_W-1:0]             r_origin_x,
    output logic [Y_W-1:0]             r_origin_y,
    output logic [SIZE_W-1:0]          r_size,
    output logic                       r_enable,
    input  logic                       r_finished,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [CHAR_W-1:0] slot_char [NUM_REQ];
    logic [X_W-1:0]    slot_x    [NUM_REQ];
    logic [Y_W-1:0]    slot_y    [NUM_REQ];
    logic [SIZE_W-1:0] slot_size [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign slot_char[i] = req_char[i*CHAR_W +: CHAR_W];
        assign slot_x[i]    = req_x[i*X_W +: X_W];
        assign slot_y[i]    = req_y[i*Y_W +: Y_W];
        assign slot_size[i] = req_size[i*SIZE_W +: SIZE_W];
    end

    sched_state_t       state;
    sched_state_t       state_next;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               any_req;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [WD_W-1:0]    watchdog;
    logic               accept;
    logic               size_zero;
    logic               finish;
    logic               abort;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .any       (any_req)
    );

    assign size_zero = (slot_size[gnt_idx] == '0);
    assign r_enable  = (state == DRAW);
    assign busy      = (state != IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    req_ready  = gnt;
                    accept     = 1'b1;
                    state_next = size_zero ? RELEASE : DRAW;
                end
            end
            DRAW: begin
                // finish takes priority over a same-cycle timeout
                if (r_finished) begin
                    finish     = 1'b1;
                    state_next = RELEASE;
                end else if (watchdog == WD_LAST) begin
                    abort      = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_char     <= '0;
            r_origin_x <= '0;
            r_origin_y <= '0;
            r_size     <= '0;
            owner      <= '0;
            rr_ptr     <= '0;
            watchdog   <= '0;
            done       <= '0;
            done_err   <= 1'b0;
        end else begin
            done     <= '0;
            done_err <= 1'b0;
            if (accept) begin
                r_char     <= slot_char[gnt_idx];
                r_origin_x <= slot_x[gnt_idx];
                r_origin_y <= slot_y[gnt_idx];
                r_size     <= slot_size[gnt_idx];
                owner      <= gnt_idx;
                rr_ptr     <= (gnt_idx == IDX_W'(NUM_REQ - 1))
                              ? '0 : gnt_idx + 1'b1;
                watchdog   <= '0;
                if (size_zero) begin
                    done <= gnt;
                end
            end
            if (state == DRAW) begin
                if (finish || abort) begin
                    done     <= ONE << owner;
                    done_err <= abort;
                    watchdog <= '0;
                end else begin
                    watchdog <= watchdog + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_char_draw_scheduler.sv
// Scoreboard bench: stimulus queues expected grants and
// completions, a negedge monitor pops and compares them.
module tb_char_draw_scheduler;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clock;
    logic           resetn;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*7-1:0] req_char;
    logic [N*8-1:0] req_x;
    logic [N*7-1:0] req_y;
    logic [N*3-1:0] req_size;
    logic [N-1:0]   done;
    logic           done_err;
    logic [6:0]     r_char;
    logic [7:0]     r_origin_x;
    logic [6:0]     r_origin_y;
    logic [2:0]     r_size;
    logic           r_enable;
    logic           r_finished;
    logic           busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [N-1:0] exp_grant [$];
    logic [N:0]   exp_done  [$];

    char_draw_scheduler #(
        .NUM_REQ (N),
        .TIMEOUT (TO)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_char   (req_char),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_size   (req_size),
        .done       (done),
        .done_err   (done_err),
        .r_char     (r_char),
        .r_origin_x (r_origin_x),
        .r_origin_y (r_origin_y),
        .r_size     (r_size),
        .r_enable   (r_enable),
        .r_finished (r_finished),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name,
                       input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    // monitor: every grant or completion must match the queue
    always @(negedge clock) begin
        if (resetn) begin
            if (|req_ready) begin
                if (exp_grant.size() == 0) begin
                    chk("unexpected_grant", int'(req_ready), 0);
                end else begin
                    chk("grant", int'(req_ready),
                        int'(exp_grant.pop_front()));
                end
            end
            if (|done || done_err) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done",
                        int'({done_err, done}), 0);
                end else begin
                    chk("done", int'({done_err, done}),
                        int'(exp_done.pop_front()));
                end
            end
        end
    end

    task automatic set_slot(input int i, input logic [6:0] c,
                            input logic [7:0] x,
                            input logic [6:0] y,
                            input logic [2:0] s);
        req_char[i*7 +: 7] = c;
        req_x[i*8 +: 8]    = x;
        req_y[i*7 +: 7]    = y;
        req_size[i*3 +: 3] = s;
    endtask

    task automatic expect_req(input int slot, input logic err);
        logic [N-1:0] oh;
        oh = N'(1) << slot;
        exp_grant.push_back(oh);
        exp_done.push_back({err, oh});
    endtask

    task automatic wait_accept(output int acc);
        acc = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (|req_ready) begin
                acc = cyc;
                @(posedge clock);
                #1;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
    endtask

    // called in first DRAW cycle; fin_at < 0 never finishes
    task automatic run_draw(input int fin_at,
                            output int en_cycles,
                            output int fin_cyc);
        en_cycles = 0;
        fin_cyc   = -1;
        for (int c = 0; c < 200; c++) begin
            if (c == fin_at) r_finished = 1'b1;
            @(negedge clock);
            if (!r_enable) return;
            en_cycles++;
            if (r_finished) fin_cyc = cyc;
            @(posedge clock);
            #1;
            r_finished = 1'b0;
        end
    endtask

    int acc;
    int en;
    int fin;
    int prev_fin;

    initial begin
        req_valid  = '0;
        req_char   = '0;
        req_x      = '0;
        req_y      = '0;
        req_size   = '0;
        r_finished = 1'b0;
        resetn     = 1'b1;
        #1 resetn  = 1'b0;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_enable", int'(r_enable), 0);
        chk("rst_done", int'({done_err, done}), 0);
        chk("rst_ops", int'({r_char, r_origin_x,
                             r_origin_y, r_size}), 0);
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;

        // contention: all held, order 0,1,2,3,0
        for (int i = 0; i < N; i++) begin
            set_slot(i, 7'(8'h30 + i), 8'(i), 7'(i), 3'd2);
        end
        for (int i = 0; i < 5; i++) expect_req(i % N, 1'b0);
        req_valid = '1;
        prev_fin  = -1;
        for (int i = 0; i < 5; i++) begin
            wait_accept(acc);
            if (i == 4) req_valid = '0;
            if (i > 0) chk("con_gap", acc - prev_fin, 2);
            chk("con_char", int'(r_char), 8'h30 + (i % N));
            run_draw(2, en, prev_fin);
            chk("con_en", en, 3);
        end

        // single draw
        @(posedge clock);
        #1;
        set_slot(0, 7'h41, 8'd10, 7'd20, 3'd2);
        expect_req(0, 1'b0);
        req_valid = 4'b0001;
        wait_accept(acc);
        req_valid = '0;
        chk("single_en", int'(r_enable), 1);
        chk("single_char", int'(r_char), 8'h41);
        chk("single_x", int'(r_origin_x), 10);
        chk("single_y", int'(r_origin_y), 20);
        chk("single_size", int'(r_size), 2);
        run_draw(9, en, fin);
        chk("single_len", en, 10);

        // size zero on slot 2
        @(posedge clock);
        #1;
        set_slot(2, 7'h5a, 8'd1, 7'd2, 3'd0);
        expect_req(2, 1'b0);
        req_valid = 4'b0100;
        wait_accept(acc);
        req_valid = '0;
        chk("sz0_en_a1", int'(r_enable), 0);
        chk("sz0_busy_a1", int'(busy), 1);
        @(posedge clock);
        #1;
        chk("sz0_en_a2", int'(r_enable), 0);
        chk("sz0_busy_a2", int'(busy), 0);

        // stray r_finished while idle
        r_finished = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("stray_busy", int'(busy), 0);
        chk("stray_en", int'(r_enable), 0);
        r_finished = 1'b0;

        // timeout on slot 3
        set_slot(3, 7'h21, 8'd200, 7'd100, 3'd1);
        expect_req(3, 1'b1);
        req_valid = 4'b1000;
        wait_accept(acc);
        req_valid = '0;
        run_draw(-1, en, fin);
        chk("timeout_len", en, TO);

        // finish on the last watchdog count
        @(posedge clock);
        #1;
        set_slot(1, 7'h7e, 8'd5, 7'd6, 3'd7);
        expect_req(1, 1'b0);
        req_valid = 4'b0010;
        wait_accept(acc);
        req_valid = '0;
        run_draw(TO - 1, en, fin);
        chk("tie_len", en, TO);

        // reset during DRAW cycle 5 on slot 2
        @(posedge clock);
        #1;
        set_slot(2, 7'h42, 8'd9, 7'd9, 3'd3);
        exp_grant.push_back(4'b0100);
        req_valid = 4'b0100;
        wait_accept(acc);
        req_valid = '0;
        repeat (5) @(posedge clock);
        #1;
        chk("mid_en_before", int'(r_enable), 1);
        resetn = 1'b0;
        #1;
        chk("mid_en_async", int'(r_enable), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_done", int'({done_err, done}), 0);
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        expect_req(0, 1'b0);
        req_valid = '1;
        wait_accept(acc);
        req_valid = '0;
        run_draw(1, en, fin);
        chk("post_rst_len", en, 2);

        repeat (3) @(posedge clock);
        #1;
        chk("grant_q_empty", exp_grant.size(), 0);
        chk("done_q_empty", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
